ysyx_22050612_seq_ctrl: RTL and testbench
=========================================

Name: ysyx_22050612_seq_ctrl

Overview:
Multi-cycle sequencer for the single-cycle EXU datapath and its general register file. It owns the PC and runs each instruction through fetch, execute, optional memory and writeback phases, using valid/ready handshakes on the fetch and data-memory sides. It gates the register-file write enable so that GPR state commits exactly once per instruction. It also halts on ebreak, on a misaligned next PC, or on a memory timeout.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum wait cycles in FETCH_WAIT or MEM before an error halt; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
ifetch_valid  out  1  fetch request to instruction memory
ifetch_ready  in  1  instruction memory accepts request
inst_valid  in  1  instruction data returned
inst  in  32  returned instruction word
inst_r  out  32  latched instruction, fed to decoder/EXU
is_load  in  1  decoder: inst_r is a load
is_store  in  1  decoder: inst_r is a store
is_ebreak  in  1  decoder: inst_r is ebreak
dnpc  in  64  next PC computed by EXU
pc  out  64  current PC, fed to EXU
mem_valid  out  1  data-memory request
mem_ready  in  1  data memory completes request
gpr_wen_gate  out  1  ANDed with the EXU write enable at the register file
halt  out  1  sticky halt
halt_err  out  1  halt cause: 1=error, 0=ebreak
instret  out  64  retired-instruction counter

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM, WB, HALT. Encoding is free; one-hot or binary are both acceptable.
- Reset is asynchronous on rst_n low and takes effect immediately, including mid-instruction or mid-handshake. Reset values:
  - state=FETCH_REQ, pc=PC_RESET, inst_r=0, instret=0
  - halt=0, halt_err=0, timeout counter=0
  - all request and gate outputs low while rst_n is low
- FETCH_REQ:
  - ifetch_valid=1, held high until the cycle ifetch_ready=1.
  - On that edge go to FETCH_WAIT.
  - inst_valid is ignored in this state.
- FETCH_WAIT:
  - On inst_valid=1, inst_r<=inst and go to EXEC.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT (and TIMEOUT!=0), go to HALT with halt_err=1.
- EXEC: one cycle, in which the decoder and EXU evaluate inst_r and pc combinationally. Priority:
  - is_ebreak: go to HALT, halt_err=0, no writeback, pc unchanged.
  - else dnpc[1:0]!=0: go to HALT, halt_err=1, no writeback, pc unchanged.
  - else is_load|is_store: go to MEM.
  - else: go to WB.
- MEM:
  - mem_valid=1 until the cycle mem_ready=1, then go to WB.
  - Same timeout rule as FETCH_WAIT.
  - mem_ready in any other state is ignored.
- WB: exactly one cycle.
  - gpr_wen_gate=1.
  - pc<=dnpc.
  - instret<=instret+1 (wraps modulo 2^64).
  - Go to FETCH_REQ.
  - gpr_wen_gate is 0 in every other state.
- HALT:
  - Sticky until reset; halt=1; no outputs toggle.
  - halt_err is held at the value set on entry.
- Timeout counter:
  - Width is clog2(TIMEOUT+1), saturating.
  - Cleared on every entry to FETCH_WAIT or MEM.
- Latency with zero-wait memory: a non-memory instruction takes 4 cycles and a load/store takes 5.
- dnpc is sampled in EXEC for the alignment check and in WB for the commit; the EXU must hold dnpc stable across both, which it does because inst_r and pc are stable.

Test Plan:
- Reset, then ifetch_ready=1, inst_valid=1 each cycle, decoder flags 0, dnpc=pc+4 -> pc steps 0x80000000, 0x80000004, ... every 4 cycles; one gpr_wen_gate pulse per instruction; instret=3 after 12 cycles.
- is_load=1, mem_ready delayed 3 cycles -> mem_valid high for exactly 4 cycles, then one WB pulse; instret+1; total 8 cycles for the instruction.
- is_ebreak=1 in EXEC -> halt=1, halt_err=0, no gpr_wen_gate pulse, pc unchanged, state stays HALT for 20 more cycles.
- dnpc=0x80000006 in EXEC -> halt=1, halt_err=1, pc unchanged, instret unchanged.
- TIMEOUT=16, inst_valid never asserted -> halt_err=1 exactly 16 cycles after entering FETCH_WAIT; with TIMEOUT=0 -> no halt after 1000 cycles.
- rst_n pulsed low during MEM with mem_valid=1 -> mem_valid drops without waiting for a clock edge; after release, pc=PC_RESET, instret=0, ifetch_valid=1 on the first cycle.

Source files
------------

// File: rtl/ysyx_22050612_seq_ctrl_if.sv
// Fetch and data-memory handshake bundle between the sequencer (master) and the memory side.
interface ysyx_22050612_seq_ctrl_if;
    logic        ifetch_valid;
    logic        ifetch_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        mem_valid;
    logic        mem_ready;

    modport master (
        output ifetch_valid,
        output mem_valid,
        input  ifetch_ready,
        input  inst_valid,
        input  inst,
        input  mem_ready
    );

    modport slave (
        input  ifetch_valid,
        input  mem_valid,
        output ifetch_ready,
        output inst_valid,
        output inst,
        output mem_ready
    );
endinterface

// File: rtl/ysyx_22050612_seq_ctrl.sv
// Multi-cycle sequencer: owns the PC, steps each instruction through fetch/exec/mem/writeback,
// opens the GPR write gate once per retired instruction and halts on ebreak, bad dnpc or timeout.
module ysyx_22050612_seq_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_22050612_seq_ctrl_if.master bus,
    output logic [31:0]              inst_r,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic                     is_ebreak,
    input  logic [63:0]              dnpc,
    output logic [63:0]              pc,
    output logic                     gpr_wen_gate,
    output logic                     halt,
    output logic                     halt_err,
    output logic [63:0]              instret
);

    localparam int unsigned     CntW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

    typedef enum logic [2:0] {
        StFetchReq  = 3'd0,
        StFetchWait = 3'd1,
        StExec      = 3'd2,
        StMem       = 3'd3,
        StWb        = 3'd4,
        StHalt      = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]     inst_q, inst_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     instret_q, instret_d;
    logic            err_q, err_d;
    logic            timeout_hit;

    // Saturating wait counter; the limit compare is disabled entirely when TIMEOUT is zero.
    assign cnt_inc     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CntLimit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetchReq;
            cnt_q     <= '0;
            inst_q    <= '0;
            pc_q      <= PC_RESET;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        err_d     = err_q;
        unique case (state_q)
            StFetchReq: begin
                if (bus.ifetch_ready) begin
                    state_d = StFetchWait;
                    cnt_d   = '0;
                end
            end
            StFetchWait: begin
                if (bus.inst_valid) begin
                    inst_d  = bus.inst;
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                end
            end
            StExec: begin
                // ebreak outranks a misaligned target; neither commits anything.
                if (is_ebreak) begin
                    state_d = StHalt;
                    err_d   = 1'b0;
                end else if (dnpc[1:0] != 2'b00) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                    cnt_d   = '0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (bus.mem_ready) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                end
            end
            StWb: begin
                pc_d      = dnpc;
                instret_d = instret_q + 64'd1;
                state_d   = StFetchReq;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetchReq;
            end
        endcase
    end

    // Request and gate outputs are forced low for as long as reset is held.
    always_comb begin
        bus.ifetch_valid = 1'b0;
        bus.mem_valid    = 1'b0;
        gpr_wen_gate     = 1'b0;
        halt             = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetchReq: bus.ifetch_valid = 1'b1;
                StMem:      bus.mem_valid    = 1'b1;
                StWb:       gpr_wen_gate     = 1'b1;
                StHalt:     halt             = 1'b1;
                default:    ;
            endcase
        end
    end

    assign inst_r   = inst_q;
    assign pc       = pc_q;
    assign instret  = instret_q;
    assign halt_err = err_q;

    a_one_phase: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.ifetch_valid, bus.mem_valid, gpr_wen_gate, halt}));
    a_halt_sticky: assert property (@(posedge clk) disable iff (!rst_n) halt |=> halt);
    a_retire_gated: assert property (@(posedge clk) disable iff (!rst_n)
        !gpr_wen_gate |=> $stable(instret));

endmodule

// File: tb/tb_ysyx_22050612_seq_ctrl.sv
// Bench for the sequencer: a phase-level reference model predicts every output each cycle,
// directed scenarios pin literal values, then randomised traffic with resets and stalls.
module tb_ysyx_22050612_seq_ctrl;

    localparam logic [63:0] PcReset    = 64'h0000_0000_8000_0000;
    localparam int          TimeoutCyc = 16;
    localparam int PhFetch = 0, PhWaitInst = 1, PhExec = 2, PhMem = 3, PhCommit = 4, PhHalted = 5;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic rst_n_z = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050612_seq_ctrl_if bus ();
    ysyx_22050612_seq_ctrl_if bus_z ();

    logic [31:0] inst_r;
    logic        is_load, is_store, is_ebreak;
    logic [63:0] dnpc, pc, instret;
    logic        gpr_wen_gate, halt, halt_err;

    logic [31:0] inst_r_z;
    logic [63:0] pc_z, instret_z;
    logic        gate_z, halt_z, halt_err_z;

    ysyx_22050612_seq_ctrl #(.PC_RESET(PcReset), .TIMEOUT(TimeoutCyc)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .inst_r       (inst_r),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_ebreak    (is_ebreak),
        .dnpc         (dnpc),
        .pc           (pc),
        .gpr_wen_gate (gpr_wen_gate),
        .halt         (halt),
        .halt_err     (halt_err),
        .instret      (instret)
    );

    // Second instance with the timeout disabled and a fetch that never returns.
    assign bus_z.ifetch_ready = 1'b1;
    assign bus_z.inst_valid   = 1'b0;
    assign bus_z.inst         = 32'd0;
    assign bus_z.mem_ready    = 1'b0;

    ysyx_22050612_seq_ctrl #(.PC_RESET(PcReset), .TIMEOUT(0)) dut_z (
        .clk          (clk),
        .rst_n        (rst_n_z),
        .bus          (bus_z),
        .inst_r       (inst_r_z),
        .is_load      (1'b0),
        .is_store     (1'b0),
        .is_ebreak    (1'b0),
        .dnpc         (64'd0),
        .pc           (pc_z),
        .gpr_wen_gate (gate_z),
        .halt         (halt_z),
        .halt_err     (halt_err_z),
        .instret      (instret_z)
    );

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_wait;
    logic [63:0] m_pc, m_instret;
    logic [31:0] m_inst;
    logic        m_err;

    task automatic model_reset();
        m_phase   = PhFetch;
        m_wait    = 0;
        m_pc      = PcReset;
        m_instret = 64'd0;
        m_inst    = 32'd0;
        m_err     = 1'b0;
    endtask

    task automatic model_step();
        case (m_phase)
            PhFetch: if (bus.ifetch_ready) begin
                m_phase = PhWaitInst;
                m_wait  = 0;
            end
            PhWaitInst: if (bus.inst_valid) begin
                m_inst  = bus.inst;
                m_phase = PhExec;
            end else begin
                m_wait++;
                if (TimeoutCyc != 0 && m_wait == TimeoutCyc) begin
                    m_phase = PhHalted;
                    m_err   = 1'b1;
                end
            end
            PhExec: if (is_ebreak) begin
                m_phase = PhHalted;
                m_err   = 1'b0;
            end else if ((dnpc % 64'd4) != 64'd0) begin
                m_phase = PhHalted;
                m_err   = 1'b1;
            end else if (is_load || is_store) begin
                m_phase = PhMem;
                m_wait  = 0;
            end else begin
                m_phase = PhCommit;
            end
            PhMem: if (bus.mem_ready) begin
                m_phase = PhCommit;
            end else begin
                m_wait++;
                if (TimeoutCyc != 0 && m_wait == TimeoutCyc) begin
                    m_phase = PhHalted;
                    m_err   = 1'b1;
                end
            end
            PhCommit: begin
                m_pc      = dnpc;
                m_instret = m_instret + 64'd1;
                m_phase   = PhFetch;
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int gate_cnt = 0;
    int mv_cnt = 0;
    int halt_age = 0;
    int stall_left = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk64(name, 64'(act), 64'(exp));
    endtask

    task automatic compare_all();
        chk1("ifetch_valid", bus.ifetch_valid, m_phase == PhFetch);
        chk1("mem_valid", bus.mem_valid, m_phase == PhMem);
        chk1("gpr_wen_gate", gpr_wen_gate, m_phase == PhCommit);
        chk1("halt", halt, m_phase == PhHalted);
        chk1("halt_err", halt_err, m_err);
        chk64("pc", pc, m_pc);
        chk64("instret", instret, m_instret);
        chk64("inst_r", 64'(inst_r), 64'(m_inst));
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) compare_all();
        if (gpr_wen_gate) gate_cnt++;
        if (bus.mem_valid) mv_cnt++;
    endtask

    task automatic pulse_reset(input int sub);
        #(sub) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic exu_set(input logic ld, input logic st, input logic eb, input logic [63:0] step);
        is_load   = ld;
        is_store  = st;
        is_ebreak = eb;
        dnpc      = m_pc + step;
    endtask

    // Emulated decoder/EXU: everything derives from the latched instruction and current PC.
    task automatic exu_rand();
        is_ebreak = (m_inst[5:0] == 6'd0);
        is_load   = (m_inst[13:12] == 2'd1);
        is_store  = (m_inst[13:12] == 2'd2);
        dnpc      = m_pc + 64'({m_inst[31:20], 2'b00}) + ((m_inst[19:14] == 6'd0) ? 64'd2 : 64'd0);
    endtask

    initial begin
        bus.ifetch_ready = 1'b0;
        bus.inst_valid   = 1'b0;
        bus.inst         = 32'd0;
        bus.mem_ready    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_ebreak = 1'b0;
        dnpc      = PcReset;
        #1;
        rst_n   = 1'b0;
        rst_n_z = 1'b0;
        #11;
        chk1("rst_ifetch_valid", bus.ifetch_valid, 1'b0);
        chk1("rst_mem_valid", bus.mem_valid, 1'b0);
        chk1("rst_gate", gpr_wen_gate, 1'b0);
        chk1("rst_halt", halt, 1'b0);
        chk1("rst_halt_err", halt_err, 1'b0);
        chk64("rst_pc", pc, PcReset);
        chk64("rst_instret", instret, 64'd0);
        chk64("rst_inst_r", 64'(inst_r), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rst_n_z = 1'b1;

        // Zero-wait straight-line code: 4 cycles per instruction.
        bus.ifetch_ready = 1'b1;
        bus.inst_valid   = 1'b1;
        bus.inst         = 32'h0000_0013;
        exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        gate_cnt = 0;
        #1 chk1("first_ifetch_valid", bus.ifetch_valid, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.inst = $urandom();
            exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        end
        chk64("seq_pc", pc, 64'h0000_0000_8000_000C);
        chk64("seq_instret", instret, 64'd3);
        chk64("seq_gate_pulses", 64'(gate_cnt), 64'd3);

        // Load with mem_ready on the 4th request cycle: 8 cycles total.
        mv_cnt   = 0;
        gate_cnt = 0;
        exu_set(1'b1, 1'b0, 1'b0, 64'd4);
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.mem_ready = (mv_cnt == 4);
            exu_set(1'b1, 1'b0, 1'b0, 64'd4);
        end
        chk64("load_instret", instret, 64'd4);
        chk64("load_pc", pc, 64'h0000_0000_8000_0010);
        chk64("load_mem_valid_cycles", 64'(mv_cnt), 64'd4);
        chk64("load_gate_pulses", 64'(gate_cnt), 64'd1);

        // Asynchronous reset in the middle of a memory request.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exu_set(1'b1, 1'b0, 1'b0, 64'd4);
            if (bus.mem_valid) break;
        end
        chk1("wait_mem_valid", bus.mem_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_mem_valid", bus.mem_valid, 1'b0);
        chk1("async_rst_ifetch_valid", bus.ifetch_valid, 1'b0);
        chk64("async_rst_pc", pc, PcReset);
        chk64("async_rst_instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exu_set(1'b0, 1'b0, 1'b1, 64'd4);
        #1;
        chk1("release_ifetch_valid", bus.ifetch_valid, 1'b1);
        chk64("release_pc", pc, PcReset);
        chk64("release_instret", instret, 64'd0);

        // ebreak: halts in EXEC with no commit, then stays put.
        gate_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            exu_set(1'b0, 1'b0, 1'b1, 64'd4);
        end
        chk1("ebreak_pre_halt", halt, 1'b0);
        tick();
        chk1("ebreak_halt", halt, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk1("ebreak_still_halt", halt, 1'b1);
        chk1("ebreak_halt_err", halt_err, 1'b0);
        chk64("ebreak_gate_pulses", 64'(gate_cnt), 64'd0);
        chk64("ebreak_pc", pc, PcReset);
        chk64("ebreak_instret", instret, 64'd0);
        chk1("ebreak_no_fetch", bus.ifetch_valid, 1'b0);

        // One good instruction, then dnpc = 0x80000006.
        pulse_reset(3);
        exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            exu_set(1'b0, 1'b0, 1'b0, (i == 3) ? 64'd2 : 64'd4);
        end
        chk64("misalign_pre_pc", pc, 64'h0000_0000_8000_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            exu_set(1'b0, 1'b0, 1'b0, 64'd2);
        end
        for (int i = 0; i < 5; i++) tick();
        chk1("misalign_halt", halt, 1'b1);
        chk1("misalign_halt_err", halt_err, 1'b1);
        chk64("misalign_pc", pc, 64'h0000_0000_8000_0004);
        chk64("misalign_instret", instret, 64'd1);

        // Fetch timeout: halt exactly 16 cycles after entering the wait.
        pulse_reset(2);
        bus.inst_valid = 1'b0;
        exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        for (int i = 0; i < 16; i++) tick();
        chk1("fetch_to_not_yet", halt, 1'b0);
        tick();
        chk1("fetch_to_halt", halt, 1'b1);
        chk1("fetch_to_err", halt_err, 1'b1);

        // Instruction arriving on the last allowed wait cycle still proceeds.
        pulse_reset(1);
        bus.inst_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        bus.inst_valid = 1'b1;
        tick();
        exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        chk1("fetch_to_edge_no_halt", halt, 1'b0);
        tick();
        exu_set(1'b0, 1'b0, 1'b0, 64'd4);
        tick();
        chk64("fetch_to_edge_instret", instret, 64'd1);

        // Memory timeout.
        pulse_reset(4);
        bus.mem_ready = 1'b0;
        exu_set(1'b1, 1'b0, 1'b0, 64'd4);
        for (int i = 0; i < 18; i++) begin
            tick();
            exu_set(1'b1, 1'b0, 1'b0, 64'd4);
        end
        chk1("mem_to_not_yet", halt, 1'b0);
        tick();
        chk1("mem_to_halt", halt, 1'b1);
        chk1("mem_to_err", halt_err, 1'b1);
        chk64("mem_to_instret", instret, 64'd0);

        // Randomised traffic with stalls and asynchronous resets.
        pulse_reset(2);
        halt_age   = 0;
        stall_left = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            halt_age = (m_phase == PhHalted) ? halt_age + 1 : 0;
            if (halt_age > 4 || $urandom_range(0, 499) == 0) begin
                pulse_reset(int'($urandom_range(1, 4)));
                halt_age = 0;
            end
            bus.ifetch_ready = ($urandom_range(0, 9) < 7);
            if (stall_left > 0) begin
                stall_left--;
                bus.inst_valid = 1'b0;
                bus.mem_ready  = 1'b0;
            end else begin
                if ($urandom_range(0, 149) == 0) stall_left = int'($urandom_range(14, 20));
                bus.inst_valid = ($urandom_range(0, 9) < 6);
                bus.mem_ready  = ($urandom_range(0, 1) == 1);
            end
            bus.inst = $urandom();
            exu_rand();
        end

        // Timeout-disabled instance has been waiting on its fetch for thousands of cycles.
        chk1("tz_no_halt", halt_z, 1'b0);
        chk1("tz_no_err", halt_err_z, 1'b0);
        chk1("tz_ifetch_idle", bus_z.ifetch_valid, 1'b0);
        chk1("tz_mem_idle", bus_z.mem_valid, 1'b0);
        chk1("tz_gate", gate_z, 1'b0);
        chk64("tz_pc", pc_z, PcReset);
        chk64("tz_instret", instret_z, 64'd0);
        chk64("tz_inst_r", 64'(inst_r_z), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
